// File: rtl/pkt_capture_pkg.sv
// Shared definitions for the packet capture/playback sequencer: state encoding
// and the packet-length code decoder.
package pkt_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_PKT_SEND = 3'd2,
    ST_PKT_IDLE = 3'd3,
    ST_DONE     = 3'd4
  } ctrl_state_t;

  localparam int PKT_LEN_BASE = 256;
  // Wide enough for the largest packet (256 << 3 = 2048 words).
  localparam int PLEN_W = 12;

  function automatic logic [PLEN_W-1:0] len_words(input logic [1:0] code);
    return PLEN_W'(PKT_LEN_BASE) << code;
  endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Loadable 16-bit down-counter timing the idle gap between packets; expire
// pulses during the last gap cycle so the FSM resumes sending on the next one.
module pkt_gap_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign expire = en && (cnt == 16'd1);

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Capture/playback sequencer: fills the capture memory with ADC samples, then
// replays it as fixed-length packets separated by idle gaps.
// Optional ramp self-test pattern: define PKT_CAPTURE_CTRL_SELF_TEST_EN.
module pkt_capture_ctrl
  import pkt_capture_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int CAP_DEPTH = 8192,
  parameter int DATA_W    = 9
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rst,
  input  logic              rf_capture_mode_sync,
  input  logic              rf_capture_start_sync,
  input  logic              rf_capture_again_sync,
  input  logic              rf_self_test_mode_sync,
  input  logic [1:0]        rf_pkt_data_length_sync,
  input  logic [15:0]       rf_pkt_idle_length_sync,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              pkt_ready,
  output logic              pkt_valid,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [2:0]        ctrl_state
);

  // One extra bit so the CAP_DEPTH == 2^ADDR_W terminal count is representable.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_WR = CW'(CAP_DEPTH - 1);
  localparam logic [CW-1:0] CAP_END = CW'(CAP_DEPTH);
  localparam logic [CW-1:0] A_ONE   = CW'(1);

  ctrl_state_t       state, state_n;
  logic [CW-1:0]     wr_addr, wr_addr_n, rd_addr, rd_addr_n;
  logic [PLEN_W-1:0] word_cnt, word_cnt_n, plen;
  logic [15:0]       idle;
  logic              start_d, again_d, start_rise, again_rise, abort;
  logic              latch, tmr_load, tmr_en, tmr_expire, eop_word;
  logic              cap_wr_en, wr_en, rd_en;
  logic [DATA_W-1:0] cap_wr_data, wr_data;
  logic              valid_q, sop_q, eop_q;

  assign start_rise = rf_capture_start_sync & ~start_d;
  assign again_rise = rf_capture_again_sync & ~again_d;
  assign abort      = (state != ST_IDLE) && !rf_capture_start_sync;
  assign eop_word   = (word_cnt == plen - PLEN_W'(1));
  assign tmr_en     = (state == ST_PKT_IDLE);

`ifdef PKT_CAPTURE_CTRL_SELF_TEST_EN
  assign cap_wr_en   = adc_valid | rf_self_test_mode_sync;
  assign cap_wr_data = rf_self_test_mode_sync ? wr_addr[DATA_W-1:0] : adc_data;
`else
  logic unused_self_test;
  assign unused_self_test = rf_self_test_mode_sync;
  assign cap_wr_en   = adc_valid;
  assign cap_wr_data = adc_data;
`endif

  pkt_gap_timer u_gap_timer (
    .clk      (pktctrl_clk),
    .rst      (pktctrl_rst),
    .load     (tmr_load),
    .load_val (idle),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_n    = state;
    wr_addr_n  = wr_addr;
    rd_addr_n  = rd_addr;
    word_cnt_n = word_cnt;
    latch      = 1'b0;
    tmr_load   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    rd_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_n   = ST_CAPTURE;
          wr_addr_n = '0;
          latch     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        wr_en   = cap_wr_en;
        wr_data = cap_wr_data;
        if (wr_en) begin
          wr_addr_n = wr_addr + A_ONE;
          if (wr_addr == LAST_WR) begin
            state_n    = ST_PKT_SEND;
            rd_addr_n  = '0;
            word_cnt_n = '0;
          end
        end
      end
      ST_PKT_SEND: begin
        rd_en = pkt_ready;
        if (rd_en) begin
          rd_addr_n  = rd_addr + A_ONE;
          word_cnt_n = word_cnt + PLEN_W'(1);
          if (eop_word) begin
            word_cnt_n = '0;
            if (rd_addr + A_ONE == CAP_END) begin
              state_n = ST_DONE;
            end else if (idle != 16'd0) begin
              state_n  = ST_PKT_IDLE;
              tmr_load = 1'b1;
            end
          end
        end
      end
      ST_PKT_IDLE: begin
        if (tmr_expire) state_n = ST_PKT_SEND;
      end
      ST_DONE: begin
        // Replay takes precedence over continuous recapture.
        if (again_rise) begin
          state_n    = ST_PKT_SEND;
          rd_addr_n  = '0;
          word_cnt_n = '0;
          latch      = 1'b1;
        end else if (rf_capture_mode_sync) begin
          state_n   = ST_CAPTURE;
          wr_addr_n = '0;
          latch     = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n    = ST_IDLE;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      tmr_load   = 1'b0;
      latch      = 1'b0;
      wr_addr_n  = wr_addr;
      rd_addr_n  = rd_addr;
      word_cnt_n = word_cnt;
    end
  end

  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst) begin
      state    <= ST_IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      word_cnt <= '0;
      plen     <= '0;
      idle     <= '0;
      start_d  <= 1'b0;
      again_d  <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state    <= state_n;
      wr_addr  <= wr_addr_n;
      rd_addr  <= rd_addr_n;
      word_cnt <= word_cnt_n;
      start_d  <= rf_capture_start_sync;
      again_d  <= rf_capture_again_sync;
      if (latch) begin
        plen <= len_words(rf_pkt_data_length_sync);
        idle <= rf_pkt_idle_length_sync;
      end
      // Tags ride alongside the 1-cycle memory read latency.
      valid_q <= rd_en;
      sop_q   <= rd_en && (word_cnt == '0);
      eop_q   <= rd_en && eop_word;
    end
  end

  assign mem_wr_en    = wr_en;
  assign mem_wr_addr  = wr_addr[ADDR_W-1:0];
  assign mem_wr_data  = wr_data;
  assign mem_rd_en    = rd_en;
  assign mem_rd_addr  = rd_addr[ADDR_W-1:0];
  assign pkt_valid    = valid_q;
  assign pkt_sop      = sop_q;
  assign pkt_eop      = eop_q;
  assign capture_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign capture_done = (state == ST_DONE);
  assign ctrl_state   = state;

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Directed bench for pkt_capture_ctrl: capture, packetised readout with gaps,
// back-to-back packets, replay, ready throttling, abort and self-test pattern.
module tb_pkt_capture_ctrl;

  localparam int ADDR_W    = 15;
  localparam int CAP_DEPTH = 8192;
  localparam int DATA_W    = 9;

  logic              pktctrl_clk = 1'b0;
  logic              pktctrl_rst = 1'b1;
  logic              rf_capture_mode_sync = 1'b0;
  logic              rf_capture_start_sync = 1'b0;
  logic              rf_capture_again_sync = 1'b0;
  logic              rf_self_test_mode_sync = 1'b0;
  logic [1:0]        rf_pkt_data_length_sync = 2'd0;
  logic [15:0]       rf_pkt_idle_length_sync = 16'd0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              pkt_ready = 1'b0;
  logic              mem_wr_en, mem_rd_en, pkt_valid, pkt_sop, pkt_eop;
  logic              capture_busy, capture_done;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [2:0]        ctrl_state;

  always #5 pktctrl_clk = ~pktctrl_clk;

  pkt_capture_ctrl #(.ADDR_W(ADDR_W), .CAP_DEPTH(CAP_DEPTH), .DATA_W(DATA_W)) dut (
    .pktctrl_clk             (pktctrl_clk),
    .pktctrl_rst             (pktctrl_rst),
    .rf_capture_mode_sync    (rf_capture_mode_sync),
    .rf_capture_start_sync   (rf_capture_start_sync),
    .rf_capture_again_sync   (rf_capture_again_sync),
    .rf_self_test_mode_sync  (rf_self_test_mode_sync),
    .rf_pkt_data_length_sync (rf_pkt_data_length_sync),
    .rf_pkt_idle_length_sync (rf_pkt_idle_length_sync),
    .adc_valid               (adc_valid),
    .adc_data                (adc_data),
    .mem_wr_en               (mem_wr_en),
    .mem_wr_addr             (mem_wr_addr),
    .mem_wr_data             (mem_wr_data),
    .mem_rd_en               (mem_rd_en),
    .mem_rd_addr             (mem_rd_addr),
    .pkt_ready               (pkt_ready),
    .pkt_valid               (pkt_valid),
    .pkt_sop                 (pkt_sop),
    .pkt_eop                 (pkt_eop),
    .capture_busy            (capture_busy),
    .capture_done            (capture_done),
    .ctrl_state              (ctrl_state)
  );

  // Capture memory with 1-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data;
  always @(posedge pktctrl_clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) rd_data <= mem[mem_rd_addr];
  end

  logic [DATA_W-1:0] exp_mem [0:CAP_DEPTH-1];
  logic [DATA_W-1:0] exp_q[$];
  int tests_run = 0;
  int fails = 0;

  task automatic step();
    @(posedge pktctrl_clk);
    #1;
  endtask

  // Drives a write per cycle with adc_valid high; expects sequential addresses.
  task automatic run_capture(input int first, input int last);
    logic [DATA_W-1:0] d;
    for (int a = first; a <= last; a++) begin
      d = DATA_W'((a * 37 + 5) % 512);
      adc_valid = 1'b1;
      adc_data  = d;
      #1;
      tests_run++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== ADDR_W'(a) || mem_wr_data !== d) begin
        fails++;
        $display("FAIL capture_write: got en=%b addr=%0d data=%0d, exp en=1 addr=%0d data=%0d",
                 mem_wr_en, mem_wr_addr, mem_wr_data, a, d);
      end
      exp_mem[a] = d;
      step();
    end
  endtask

  // Follows the readout phase with a reference packet/gap model until DONE.
  task automatic run_readout(input int plen, input int idle, input bit toggle);
    int exp_addr = 0;
    int w = 0;
    int gap = 0;
    int cyc = 0;
    bit done = 0;
    bit pend_v = 0, pend_sop = 0, pend_eop = 0, exp_rd;
    logic [DATA_W-1:0] e;
    exp_q.delete();
    while (!done && cyc < 40000) begin
      pkt_ready = toggle ? ~cyc[0] : 1'b1;
      #1;
      tests_run++;
      if (pkt_valid !== pend_v || pkt_sop !== pend_sop || pkt_eop !== pend_eop) begin
        fails++;
        $display("FAIL pkt_tags: got v/s/e=%b%b%b, exp %b%b%b (cyc %0d)",
                 pkt_valid, pkt_sop, pkt_eop, pend_v, pend_sop, pend_eop, cyc);
      end
      if (pend_v) begin
        e = exp_q.pop_front();
        tests_run++;
        if (rd_data !== e) begin
          fails++;
          $display("FAIL pkt_data: got %0d, exp %0d (cyc %0d)", rd_data, e, cyc);
        end
      end
      exp_rd = (gap == 0) && pkt_ready;
      tests_run++;
      if (mem_rd_en !== exp_rd || mem_wr_en !== 1'b0) begin
        fails++;
        $display("FAIL rd_en: got rd=%b wr=%b, exp rd=%b wr=0 (cyc %0d)",
                 mem_rd_en, mem_wr_en, exp_rd, cyc);
      end
      pend_sop = 1'b0;
      pend_eop = 1'b0;
      if (exp_rd) begin
        tests_run++;
        if (mem_rd_addr !== ADDR_W'(exp_addr)) begin
          fails++;
          $display("FAIL rd_addr: got %0d, exp %0d", mem_rd_addr, exp_addr);
        end
        exp_q.push_back(exp_mem[exp_addr]);
        pend_sop = (w == 0);
        pend_eop = (w == plen - 1);
        exp_addr++;
        w++;
        if (w == plen) begin
          w = 0;
          if (exp_addr == CAP_DEPTH) done = 1;
          else gap = idle;
        end
      end else if (gap > 0) begin
        gap--;
      end
      pend_v = exp_rd;
      step();
      cyc++;
    end
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL readout_timeout: got %0d words read, exp %0d", exp_addr, CAP_DEPTH);
    end else begin
      e = exp_q.pop_front();
      if (pkt_valid !== 1'b1 || pkt_eop !== 1'b1 || rd_data !== e || ctrl_state !== 3'd4 ||
          capture_done !== 1'b1 || capture_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL readout_end: got v=%b eop=%b data=%0d state=%0d done=%b busy=%b rd=%b, exp 1 1 %0d 4 1 0 0",
                 pkt_valid, pkt_eop, rd_data, ctrl_state, capture_done, capture_busy, mem_rd_en, e);
      end
    end
  endtask

  task automatic test_reset();
    pktctrl_rst = 1'b1;
    adc_data    = 9'h1AB;
    adc_valid   = 1'b1;
    repeat (3) step();
    pktctrl_rst = 1'b0;
    step();
    tests_run++;
    if (ctrl_state !== 3'd0 || capture_busy !== 1'b0 || capture_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got state=%0d busy=%b done=%b, exp 0 0 0", ctrl_state, capture_busy, capture_done);
    end
    tests_run++;
    if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_addr !== '0 || mem_rd_addr !== '0 || mem_wr_data !== '0) begin
      fails++;
      $display("FAIL reset_mem: got wr=%b rd=%b wa=%0d ra=%0d wd=%0d, exp all 0",
               mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data);
    end
    tests_run++;
    if (pkt_valid !== 1'b0 || pkt_sop !== 1'b0 || pkt_eop !== 1'b0) begin
      fails++;
      $display("FAIL reset_pkt: got v/s/e=%b%b%b, exp 000", pkt_valid, pkt_sop, pkt_eop);
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_capture_packets();
    rf_pkt_data_length_sync = 2'd0;
    rf_pkt_idle_length_sync = 16'd4;
    rf_capture_start_sync   = 1'b1;
    pkt_ready = 1'b1;
    step();
    tests_run++;
    if (ctrl_state !== 3'd1 || capture_busy !== 1'b1) begin
      fails++;
      $display("FAIL start_capture: got state=%0d busy=%b, exp 1 1", ctrl_state, capture_busy);
    end
    // Register changes mid-run must not alter the latched packet geometry.
    rf_pkt_data_length_sync = 2'd3;
    rf_pkt_idle_length_sync = 16'd0;
    run_capture(0, CAP_DEPTH - 1);
    tests_run++;
    if (ctrl_state !== 3'd2) begin
      fails++;
      $display("FAIL capture_to_send: got state=%0d, exp 2", ctrl_state);
    end
    run_readout(256, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    rf_capture_again_sync = 1'b1;
    step();
    tests_run++;
    if (ctrl_state !== 3'd2) begin
      fails++;
      $display("FAIL replay_start: got state=%0d, exp 2", ctrl_state);
    end
    run_readout(2048, 0, 1'b0);
    rf_capture_again_sync = 1'b0;
    step();
    tests_run++;
    if (capture_done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: got done=%b, exp 1", capture_done);
    end
  endtask

  task automatic test_replay_vs_mode_ready_toggle();
    rf_pkt_data_length_sync = 2'd1;
    rf_pkt_idle_length_sync = 16'd2;
    rf_capture_again_sync   = 1'b1;
    rf_capture_mode_sync    = 1'b1;
    step();
    tests_run++;
    if (ctrl_state !== 3'd2 || mem_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL replay_priority: got state=%0d wr=%b, exp 2 0", ctrl_state, mem_wr_en);
    end
    rf_capture_mode_sync = 1'b0;
    run_readout(512, 2, 1'b1);
    rf_capture_again_sync = 1'b0;
  endtask

  task automatic test_abort_restart_continuous();
    int n;
    rf_capture_start_sync = 1'b0;
    step();
    tests_run++;
    if (ctrl_state !== 3'd0 || capture_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_done: got state=%0d done=%b, exp 0 0", ctrl_state, capture_done);
    end
    rf_capture_start_sync = 1'b1;
    step();
    run_capture(0, 999);
    rf_capture_start_sync = 1'b0;
    #1;
    tests_run++;
    if (mem_wr_en !== 1'b0 || mem_wr_addr !== ADDR_W'(1000)) begin
      fails++;
      $display("FAIL abort_wr: got en=%b addr=%0d, exp 0 1000", mem_wr_en, mem_wr_addr);
    end
    step();
    tests_run++;
    if (ctrl_state !== 3'd0) begin
      fails++;
      $display("FAIL abort_idle: got state=%0d, exp 0", ctrl_state);
    end
    rf_pkt_data_length_sync = 2'd3;
    rf_pkt_idle_length_sync = 16'd0;
    rf_capture_start_sync   = 1'b1;
    step();
    adc_valid = 1'b0;
    rf_self_test_mode_sync = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests_run++;
`ifdef PKT_CAPTURE_CTRL_SELF_TEST_EN
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== ADDR_W'(k) || mem_wr_data !== DATA_W'(k)) begin
        fails++;
        $display("FAIL self_test_ramp: got en=%b addr=%0d data=%0d, exp 1 %0d %0d",
                 mem_wr_en, mem_wr_addr, mem_wr_data, k, k);
      end
      exp_mem[k] = DATA_W'(k);
`else
      if (mem_wr_en !== 1'b0 || mem_wr_addr !== '0) begin
        fails++;
        $display("FAIL self_test_off: got en=%b addr=%0d, exp 0 0", mem_wr_en, mem_wr_addr);
      end
`endif
      step();
    end
    rf_self_test_mode_sync = 1'b0;
`ifdef PKT_CAPTURE_CTRL_SELF_TEST_EN
    n = 8;
`else
    n = 0;
`endif
    run_capture(n, CAP_DEPTH - 1);
    adc_valid = 1'b0;
    run_readout(2048, 0, 1'b0);
    rf_capture_mode_sync = 1'b1;
    step();
    tests_run++;
    if (ctrl_state !== 3'd1 || capture_busy !== 1'b1 || mem_wr_addr !== '0) begin
      fails++;
      $display("FAIL continuous: got state=%0d busy=%b addr=%0d, exp 1 1 0", ctrl_state, capture_busy, mem_wr_addr);
    end
    rf_capture_mode_sync  = 1'b0;
    rf_capture_start_sync = 1'b0;
    step();
    tests_run++;
    if (ctrl_state !== 3'd0) begin
      fails++;
      $display("FAIL final_abort: got state=%0d, exp 0", ctrl_state);
    end
  endtask

  initial begin
    test_reset();
    test_capture_packets();
    test_back_to_back();
    test_replay_vs_mode_ready_toggle();
    test_abort_restart_continuous();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
